// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: holds operand vectors A and B written by a host, streams
// element pairs into a free-running multiply-accumulate unit on start, waits out
// the MAC pipeline, then reports the run's dot product as the accumulator delta.
// Optional feature macro: MAC_OPERAND_SEQUENCER_ACC_CLR_EN adds an acc_clr pulse
// for MACs with a synchronous clear and reports mac_result directly.
module mac_operand_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  output logic                     busy,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic                     op_valid,
  input  logic [ACC_W-1:0]         mac_result,
  output logic [ACC_W-1:0]         result,
  output logic                     done
`ifdef MAC_OPERAND_SEQUENCER_ACC_CLR_EN
  ,
  output logic                     acc_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAC_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]   LEN_MAX    = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(MAC_LAT - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_buf_a [DEPTH];
  logic [DATA_W-1:0] r_buf_b [DEPTH];
  logic [AW:0]       r_len_q;
  logic [AW:0]       r_idx;
  logic [CW-1:0]     r_drain_cnt;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_op_valid;
  logic              r_busy;
  logic [ACC_W-1:0]  r_result;
  logic              r_done;

  logic              w_idle;
  logic              w_wr;
  logic              w_start;
  logic [AW:0]       w_len_clamped;
  logic [DATA_W-1:0] w_first_a;
  logic [DATA_W-1:0] w_first_b;
  logic [ACC_W-1:0]  w_base;

  assign w_idle        = (r_state == S_IDLE);
  assign w_wr          = wr_en && w_idle;
  assign w_start       = start && w_idle;
  assign w_len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

  // Element 0 is loaded at the start edge, so a same-cycle host write to it is forwarded.
  assign w_first_a = (w_wr && !wr_sel && (wr_addr == '0)) ? wr_data : r_buf_a[0];
  assign w_first_b = (w_wr &&  wr_sel && (wr_addr == '0)) ? wr_data : r_buf_b[0];

  // Host write port into the operand buffers; only honoured while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else if (w_wr) begin
      if (wr_sel) r_buf_b[wr_addr] <= wr_data;
      else        r_buf_a[wr_addr] <= wr_data;
    end
  end

`ifdef MAC_OPERAND_SEQUENCER_ACC_CLR_EN
  logic r_acc_clr;

  // Clear pulse lands in the first cycle of the run, ahead of the first product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc_clr <= 1'b0;
    else        r_acc_clr <= w_start;
  end

  assign acc_clr = r_acc_clr;
  assign w_base  = '0;
`else
  logic [ACC_W-1:0] r_base;

  // Snapshot of the accumulator at start; it is stable while idle since operands are 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_base <= '0;
    else if (w_start) r_base <= mac_result;
  end

  assign w_base = r_base;
`endif

  // Run sequencing: IDLE -> ISSUE (len_q cycles) -> DRAIN (MAC_LAT cycles) -> DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len_q     <= '0;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_len_q     <= w_len_clamped;
            r_busy      <= 1'b1;
            r_drain_cnt <= '0;
            if (w_len_clamped != '0) begin
              r_state    <= S_ISSUE;
              r_op_a     <= w_first_a;
              r_op_b     <= w_first_b;
              r_op_valid <= 1'b1;
              r_idx      <= (AW+1)'(1);
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_ISSUE: begin
          if (r_idx == r_len_q) begin
            r_state     <= S_DRAIN;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_valid  <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            r_op_a <= r_buf_a[r_idx[AW-1:0]];
            r_op_b <= r_buf_b[r_idx[AW-1:0]];
            r_idx  <= r_idx + (AW+1)'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state  <= S_DONE;
            r_result <= mac_result - w_base;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_valid = r_op_valid;
  assign result   = r_result;
  assign done     = r_done;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed table-driven bench with a free-running
// two-stage unsigned MAC model (product register then accumulator, 2-cycle latency).
module tb_mac_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [4:0]  len = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic [31:0] mac_result;
  logic [31:0] result;
  logic        done;
  logic        acc_clr;

  int checks = 0;
  int failures = 0;

  logic [15:0] ma [16];
  logic [15:0] mb [16];

  typedef struct {
    logic [4:0]       len;
    logic [3:0][15:0] a4;
    logic [3:0][15:0] b4;
    logic [15:0]      fa;
    logic [15:0]      fb;
    logic [31:0]      exp_res;
    int               exp_valid;
    int               exp_dc;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  mac_operand_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len        (len),
    .start      (start),
    .busy       (busy),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .mac_result (mac_result),
    .result     (result),
    .done       (done)
`ifdef MAC_OPERAND_SEQUENCER_ACC_CLR_EN
    ,
    .acc_clr    (acc_clr)
`endif
  );

`ifndef MAC_OPERAND_SEQUENCER_ACC_CLR_EN
  assign acc_clr = 1'b0;
`endif

  // MAC model: operands presented in cycle k show up in the accumulator in cycle k+2.
  logic [31:0] m_prod;
  logic [31:0] m_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prod <= '0;
      m_acc  <= '0;
    end else begin
      m_prod <= {16'b0, op_a} * {16'b0, op_b};
      m_acc  <= acc_clr ? 32'd0 : m_acc + m_prod;
    end
  end
  assign mac_result = m_acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = data;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input int i);
    for (int k = 0; k < 16; k++) begin
      wr(1'b0, k, (k < 4) ? tbl[i].a4[k] : tbl[i].fa);
      wr(1'b1, k, (k < 4) ? tbl[i].b4[k] : tbl[i].fb);
    end
  endtask

  // Start a run at the current negedge and follow it to the done pulse.
  task automatic run(input logic [4:0] l, input bit poke, input logic [31:0] exp_res,
                     input int exp_valid, input int exp_dc);
    int c;
    int nv;
    int dc;
    int nd;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    c  = 1;
    nv = 0;
    dc = -1;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    while (dc < 0 && c <= 40) begin
      if (op_valid) begin
        if (nv < 16) begin
          chk("op_a_pair", {16'b0, op_a}, {16'b0, ma[nv]});
          chk("op_b_pair", {16'b0, op_b}, {16'b0, mb[nv]});
        end
        nv++;
      end else begin
        chk("idle_operands", {op_a, op_b}, 32'd0);
      end
      if (done) begin
        dc = c;
      end else begin
        if (poke && c == 1) begin
          start   = 1'b1;
          wr_en   = 1'b1;
          wr_sel  = 1'b0;
          wr_addr = 4'd0;
          wr_data = 16'h1234;
        end else if (poke && c == 2) begin
          start = 1'b0;
          wr_en = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
    chk("valid_count", nv, exp_valid);
    chk("done_cycle", dc, exp_dc);
    chk("result", result, exp_res);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("single_done", nd, 0);
  endtask

  initial begin
    // Basic run
    tbl[0].len = 5'd4;  tbl[0].a4 = {16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0].b4 = {16'd8, 16'd7, 16'd6, 16'd5}; tbl[0].fa = 16'd0; tbl[0].fb = 16'd0;
    tbl[0].exp_res = 32'd70; tbl[0].exp_valid = 4; tbl[0].exp_dc = 7;
    // Full-scale back-to-back run; base cancels the prior 70
    tbl[1].len = 5'd16; tbl[1].a4 = {4{16'hFFFF}}; tbl[1].b4 = {4{16'hFFFF}};
    tbl[1].fa = 16'hFFFF; tbl[1].fb = 16'hFFFF;
    tbl[1].exp_res = 32'hFFE00010; tbl[1].exp_valid = 16; tbl[1].exp_dc = 19;
    // Zero length
    tbl[2].len = 5'd0;  tbl[2].a4 = {4{16'd9}}; tbl[2].b4 = {4{16'd9}};
    tbl[2].fa = 16'd9; tbl[2].fb = 16'd9;
    tbl[2].exp_res = 32'd0; tbl[2].exp_valid = 0; tbl[2].exp_dc = 3;
    // len 20 clamps to 16: 2*(1+2+3+4+12*5) = 140
    tbl[3].len = 5'd20; tbl[3].a4 = {16'd4, 16'd3, 16'd2, 16'd1};
    tbl[3].b4 = {4{16'd2}}; tbl[3].fa = 16'd5; tbl[3].fb = 16'd2;
    tbl[3].exp_res = 32'd140; tbl[3].exp_valid = 16; tbl[3].exp_dc = 19;
    // Two elements, wide operand: 7*3 + 0x8000*4 = 0x20015
    tbl[4].len = 5'd2;  tbl[4].a4 = {16'd0, 16'd0, 16'h8000, 16'd7};
    tbl[4].b4 = {16'd0, 16'd0, 16'd4, 16'd3}; tbl[4].fa = 16'd0; tbl[4].fb = 16'd0;
    tbl[4].exp_res = 32'h00020015; tbl[4].exp_valid = 2; tbl[4].exp_dc = 5;

    for (int k = 0; k < 16; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_valid", {31'b0, op_valid}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_ops", {op_a, op_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load(i);
      run(tbl[i].len, 1'b0, tbl[i].exp_res, tbl[i].exp_valid, tbl[i].exp_dc);
    end

    // start and a write to A[0] during ISSUE are ignored
    load(0);
    run(5'd4, 1'b1, 32'd70, 4, 7);
    run(5'd1, 1'b0, 32'd5, 1, 4);

    // Write in the same cycle as start is visible to the run: 10*5
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = 4'd0;
    wr_data = 16'd10;
    ma[0]   = 16'd10;
    run(5'd1, 1'b0, 32'd50, 1, 4);

    // Asynchronous reset during the third ISSUE cycle
    load(0);
    len   = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_valid_before", {31'b0, op_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_busy", {31'b0, busy}, 32'd0);
    chk("midrun_valid", {31'b0, op_valid}, 32'd0);
    chk("midrun_ops", {op_a, op_b}, 32'd0);
    chk("midrun_result", result, 32'd0);
    chk("midrun_done", {31'b0, done}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int nd;
      nd = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("midrun_no_done", nd, 0);
    end
    wr(1'b0, 0, 16'd3);
    wr(1'b1, 0, 16'd9);
    run(5'd1, 1'b0, 32'd27, 1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
